// File: rtl/song_player.sv
// Song sequencer: steps a 13-bit ROM of {dur, note} words, drives Pin_Note for dur*TICKS_PER_UNIT, then GAP_TICKS of silence.
// Two-cycle ROM fetch per note; pause freezes playback in place; start restarts from address 0 from any state.
module song_player #(
  parameter int TICKS_PER_UNIT = 12_500_000,
  parameter int GAP_TICKS      = 1_250_000,
  parameter int ADDR_W         = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [12:0]       rom_data,
  output logic [9:0]        Pin_Note,
  output logic              busy,
  output logic              done
);

  // GAP_TICKS is expected to fit within the 7-unit counter range.
  localparam int CNT_W = $clog2(7 * TICKS_PER_UNIT + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, PAUSED} state_t;

  state_t            state, state_n, saved, saved_n;
  logic [CNT_W-1:0]  cnt, cnt_n, play_last;
  logic              fph, fph_n;
  logic [9:0]        note_r, note_n, pin_n;
  logic [2:0]        dur_r, dur_n;
  logic [ADDR_W-1:0] addr_n;
  logic              done_n;

  assign play_last = CNT_W'(32'(dur_r) * TICKS_PER_UNIT - 1);

  always_comb begin
    state_n = state;
    saved_n = saved;
    cnt_n   = cnt;
    fph_n   = fph;
    note_n  = note_r;
    dur_n   = dur_r;
    addr_n  = rom_addr;
    pin_n   = Pin_Note;
    done_n  = 1'b0;
    if (start) begin
      state_n = FETCH;
      addr_n  = '0;
      cnt_n   = '0;
      fph_n   = 1'b0;
      pin_n   = '0;
    end else begin
      case (state)
        IDLE: pin_n = '0;
        FETCH: begin
          pin_n = '0;
          if (!fph) begin
            fph_n = 1'b1;
          end else begin
            // rom_data now reflects rom_addr issued on the previous cycle
            fph_n  = 1'b0;
            note_n = rom_data[9:0];
            dur_n  = rom_data[12:10];
            cnt_n  = '0;
            if (rom_data[12:10] == 3'd0) begin
              if (loop_en) begin
                state_n = FETCH;
                addr_n  = '0;
              end else begin
                state_n = IDLE;
                done_n  = 1'b1;
              end
            end else begin
              state_n = PLAY;
              pin_n   = rom_data[9:0];
            end
          end
        end
        PLAY: begin
          pin_n = note_r;
          if (cnt == play_last) begin
            state_n = GAP;
            cnt_n   = '0;
            pin_n   = '0;
          end else begin
            // The cycle that sees pause still counts, so total PLAY time is exact.
            cnt_n = cnt + 1'b1;
            if (pause) begin
              state_n = PAUSED;
              saved_n = PLAY;
            end
          end
        end
        GAP: begin
          pin_n = '0;
          if (cnt == GAP_LAST) begin
            state_n = FETCH;
            addr_n  = rom_addr + 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
            if (pause) begin
              state_n = PAUSED;
              saved_n = GAP;
            end
          end
        end
        PAUSED: if (!pause) state_n = saved;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      saved    <= IDLE;
      cnt      <= '0;
      fph      <= 1'b0;
      note_r   <= '0;
      dur_r    <= '0;
      rom_addr <= '0;
      Pin_Note <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      saved    <= saved_n;
      cnt      <= cnt_n;
      fph      <= fph_n;
      note_r   <= note_n;
      dur_r    <= dur_n;
      rom_addr <= addr_n;
      Pin_Note <= pin_n;
      busy     <= (state_n != IDLE);
      done     <= done_n;
    end
  end

endmodule
